// File: rtl/crc_create.sv
// crc_create: bit-serial MSB-first CRC generator/checker.
// Raw LFSR remainder, no reflection, no output XOR.
module crc_create #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(8'h07),
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             init,
  input  logic             enable,
  output logic [WIDTH-1:0] crc
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("crc_create: WIDTH must be 3..32");
  end

  logic             fb;
  logic [WIDTH-1:0] shifted;

  assign fb      = crc[WIDTH-1] ^ bit_in;
  assign shifted = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

  // CRC register: reset/init reload, else shift one bit when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= INIT_VAL;
    end else if (init) begin
      crc <= INIT_VAL;
    end else if (enable) begin
      crc <= shifted;
    end
  end

endmodule

// File: tb/tb_crc_create.sv
// tb_crc_create: scoreboard bench for crc_create.
// CRC-8 and CAN CRC-15 instances share one stimulus stream.
module tb_crc_create;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        enable;
  logic        bit_in;
  logic [7:0]  crc8;
  logic [14:0] crc15;

  always #5 clk = ~clk;

  crc_create #(
    .WIDTH(8), .POLY(8'h07), .INIT_VAL(8'h00)
  ) dut8 (
    .clk(clk), .rst(rst), .bit_in(bit_in),
    .init(init), .enable(enable), .crc(crc8)
  );

  crc_create #(
    .WIDTH(15), .POLY(15'h4599), .INIT_VAL(15'h0000)
  ) dut15 (
    .clk(clk), .rst(rst), .bit_in(bit_in),
    .init(init), .enable(enable), .crc(crc15)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [7:0]  e8;
    logic [14:0] e15;
  } exp_t;

  exp_t sb[$];
  bit   msg[$];
  int   cnt   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cnt <= cnt + 1;

  // Remainder of M(x)*x^w divided by x^w+poly, by long division on a bit list.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input bit m[$]);
    bit d[$];
    logic [31:0] r;
    d = m;
    for (int k = 0; k < w; k++) d.push_back(1'b0);
    for (int i = 0; i < m.size(); i++) begin
      if (d[i]) begin
        d[i] = 1'b0;
        for (int j = 0; j < w; j++) d[i+1+j] = d[i+1+j] ^ poly[w-1-j];
      end
    end
    r = '0;
    for (int j = 0; j < w; j++) r = (r << 1) | 32'(d[m.size()+j]);
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Monitor: compare every expectation whose clock edge has passed
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cnt) begin
      e = sb.pop_front();
      chk({e.name, "/crc8"}, 32'(crc8), 32'(e.e8));
      chk({e.name, "/crc15"}, 32'(crc15), 32'(e.e15));
    end
  end

  task automatic step(input bit i, input bit e, input bit b, input bit chk_on,
                      input string n, input bit usek, input logic [7:0] k);
    exp_t x;
    @(negedge clk);
    init   = i;
    enable = e;
    bit_in = b;
    if (i) msg.delete();
    else if (e) msg.push_back(b);
    if (chk_on) begin
      x.cyc  = cnt + 1;
      x.name = n;
      x.e8   = usek ? k : 8'(ref_crc(8, 32'h07, msg));
      x.e15  = 15'(ref_crc(15, 32'h4599, msg));
      sb.push_back(x);
    end
  endtask

  task automatic shift_byte(input logic [7:0] v, input string n,
                            input bit usek, input logic [7:0] k);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, v[7-i], 1'b1, n, usek && (i == 7), k);
  endtask

  task automatic do_init();
    step(1'b1, 1'b0, 1'($urandom), 1'b1, "init", 1'b1, 8'h00);
  endtask

  task automatic rst_pulse();
    exp_t x;
    @(negedge clk);
    init   = 1'b0;
    enable = 1'b0;
    bit_in = 1'($urandom);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/crc8", 32'(crc8), 32'h0);
    chk("rst_mid/crc15", 32'(crc15), 32'h0);
    #1 rst = 1'b0;
    msg.delete();
    x.cyc  = cnt + 1;
    x.name = "rst_mid_hold";
    x.e8   = 8'h00;
    x.e15  = 15'h0000;
    sb.push_back(x);
  endtask

  initial begin
    logic [7:0] a2k [8];
    logic [7:0] a2;
    string      s;
    a2k = '{8'h07, 8'h0E, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hB0, 8'h67};
    a2  = 8'hA2;
    s   = "123456789";
    rst = 1'b0; init = 1'b0; enable = 1'b0; bit_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async/crc8", 32'(crc8), 32'h0);
    chk("rst_async/crc15", 32'(crc15), 32'h0);
    @(negedge clk) rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, "reset_state", 1'b1, 8'h00);

    do_init();
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, a2[7-i], 1'b1, "a2_step", 1'b1, a2k[i]);
    step(1'b0, 1'b0, 1'b1, 1'b1, "a2_hold", 1'b1, 8'h67);
    shift_byte(8'h67, "residue", 1'b1, 8'h00);

    do_init();
    for (int i = 0; i < 8; i++) begin
      if (i == 4)
        for (int j = 0; j < 3; j++)
          step(1'b0, 1'b0, 1'($urandom), 1'b1, "gap_idle", 1'b0, 8'h00);
      step(1'b0, 1'b1, a2[7-i], 1'b1, "gap", i == 7, 8'h67);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, "init_and_en", 1'b1, 8'h00);

    do_init();
    for (int c = 0; c < 9; c++)
      shift_byte(s[c], "ascii", c == 8, 8'hF4);

    do_init();
    shift_byte(8'hFF, "ff", 1'b1, 8'hF3);
    do_init();
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, "zero", 1'b1, 8'h00);

    do_init();
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, a2[7-i], 1'b1, "pre_rst", 1'b0, 8'h00);
    rst_pulse();
    shift_byte(a2, "post_rst", 1'b1, 8'h67);

    for (int m = 0; m < 1000; m++) begin
      int len;
      len = $urandom_range(1, 96);
      step(1'b1, 1'b0, 1'($urandom), 1'b0, "", 1'b0, 8'h00);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 15) == 0)
          step(1'b0, 1'b0, 1'($urandom), 1'b0, "", 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'($urandom), j == len - 1, "sweep", 1'b0, 8'h00);
      end
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL timeout: bench did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_create.md
# crc_create

Bit-serial CRC generator/checker for the CAN-craft datapath. Shifts one message bit per enabled clock into an LFSR-style CRC register, MSB-first, and exposes the running remainder continuously. Default configuration is CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no output XOR. The framer uses it for transmit CRC; the receiver uses it for residue checking.

## Interface
- WIDTH, 8: CRC register width in bits (legal range 3..32).
- POLY, 8'h07: generator polynomial, implicit x^WIDTH term omitted. Bit i is the x^i coefficient.
- INIT_VAL, 8'h00: value loaded on reset and on `init`.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high. Loads `crc` with INIT_VAL immediately.
- bit_in  input  1  serial message bit, consumed MSB-first. Sampled only when `enable`=1 and `init`=0.
- init  input  1  synchronous re-initialise strobe. Loads INIT_VAL at the next rising edge.
- enable  input  1  shift strobe. Consumes one `bit_in` per rising edge while high.
- crc  output  WIDTH  current CRC register contents, registered output.

## Operation
- Single register `crc[WIDTH-1:0]`.
- Priority, highest first: `rst` (asynchronous), `init`, `enable`, hold.
- On an enabled shift:
  - fb = crc[WIDTH-1] XOR bit_in.
  - crc_next = {crc[WIDTH-2:0],1'b0} XOR (fb ? POLY : 0).
- If neither `init` nor `enable` is high, `crc` holds its value. `bit_in` is ignored.
- `init` and `enable` both high in one cycle: `init` wins. The bit is discarded, not shifted.
- No output XOR and no bit reflection. `crc` is the raw register.
  - The result after N shifts equals the standard non-reflected CRC of the N-bit message with the given POLY/INIT_VAL.
- Residue property with INIT_VAL=0: shifting a message followed by its own CRC (MSB-first) leaves `crc`=0. Receivers test for zero.
- There is no internal bit counter and no frame boundary. The caller controls message length by the number of enabled cycles.
- Unknown or X on `bit_in` while `enable`=0 must not affect `crc`.

## Timing
- Reset: `crc` = INIT_VAL asynchronously on `rst` assertion. It stays there while `rst` is high. Release is synchronous to the next edge, with no shift on the release edge unless `enable` is high.
- Latency: one cycle. The effect of the `bit_in` sampled at rising edge k is visible on `crc` after edge k.
- Throughput: one bit per clock. Back-to-back enable cycles have no bubbles.
- `init` takes effect at the edge where it is sampled high. Shifting may begin on the very next edge.
- Inputs are expected stable around the rising edge. Drivers change `bit_in` on the falling edge or just after the rising edge.
- Reset mid-message aborts the computation. The next message must start from INIT_VAL; no partial state survives.
- Combinational path: none from inputs to `crc`. The output is purely registered.

## Test plan
- Reset, then `init` for 1 cycle, then `enable` for 8 cycles with bits of 8'hA2 MSB-first (1,0,1,0,0,0,1,0), then `enable`=0 for 1 cycle.
  - Required: `crc`=8'h67, held on the idle cycle.
  - Intermediate values after each shift: 07, 0E, 1B, 36, 6C, D8, B0, 67.
- ASCII "123456789" (72 bits, MSB-first per byte) after `init` -> `crc`=8'hF4.
- Bytes 8'hFF -> 8'hF3; 8'h00 -> 8'h00 (stays zero for all 8 shifts).
- Residue: 8'hA2 followed by 8'h67 (16 shifts) -> `crc`=8'h00.
- Control corner cases:
  - `enable` toggled low for 3 cycles mid-byte with random `bit_in` -> final CRC unchanged (0x67 for 0xA2).
  - `init` and `enable` both high -> `crc`=INIT_VAL.
  - `rst` pulsed between clock edges mid-message -> `crc`=0x00 immediately, without waiting for a clock edge.
- Parameter sweep: WIDTH=15, POLY=15'h4599, INIT_VAL=0 (CAN CRC-15) checked against a bit-level software model over 1000 random messages of length 1..96.
